// File: rtl/clk_div_bank.sv
// Bank of independent programmable clock dividers with shadowed divisors.
// Ports: clk, reset (async high), wr_en/wr_ch/wr_div write path, ch_en, div_clk/tick/busy per channel.
module clk_div_bank #(
  parameter int NUM_CH  = 4,
  parameter int CNT_W   = 16,
  parameter int RST_DIV = 2,
  localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [CH_W-1:0]   wr_ch,
  input  logic [CNT_W-1:0]  wr_div,
  input  logic [NUM_CH-1:0] ch_en,
  output logic [NUM_CH-1:0] div_clk,
  output logic [NUM_CH-1:0] tick,
  output logic [NUM_CH-1:0] busy
);

  localparam logic [CNT_W-1:0] RST_D = CNT_W'(RST_DIV);
  localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] div_q, div_d;
    logic [CNT_W-1:0] sdiv_q, sdiv_d;
    logic [CNT_W-1:0] div_eff;
    logic             pend_q, pend_d;
    logic             clk_q, clk_d;
    logic             tick_q, tick_d;
    logic             wr_hit, wrap, apply;

    always_comb begin
      // Out-of-range channels never match an index, so
      // such writes fall away without touching any state.
      wr_hit  = wr_en && (wr_ch == CH_W'(i)) &&
                (wr_div != '0);
      wrap    = (cnt_q == div_q - ONE);
      // A disabled channel has no period to protect,
      // so a pending divisor lands on the next edge.
      apply   = pend_q && (!ch_en[i] || wrap);
      div_eff = apply ? sdiv_q : div_q;
      cnt_d   = wrap ? '0 : cnt_q + ONE;
      clk_d   = (cnt_d < (div_eff >> 1));
      tick_d  = (cnt_d == '0);
      if (!ch_en[i]) begin
        cnt_d  = '0;
        clk_d  = 1'b0;
        tick_d = 1'b0;
      end
      div_d   = div_eff;
      // Apply consumes the old shadow value; a same-edge
      // write refills the shadow and keeps pending set.
      sdiv_d  = wr_hit ? wr_div : sdiv_q;
      pend_d  = wr_hit | (pend_q & ~apply);
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        cnt_q  <= '0;
        div_q  <= RST_D;
        sdiv_q <= RST_D;
        pend_q <= 1'b0;
        clk_q  <= 1'b0;
        tick_q <= 1'b0;
      end else begin
        cnt_q  <= cnt_d;
        div_q  <= div_d;
        sdiv_q <= sdiv_d;
        pend_q <= pend_d;
        clk_q  <= clk_d;
        tick_q <= tick_d;
      end
    end

    assign div_clk[i] = clk_q;
    assign tick[i]    = tick_q;
    assign busy[i]    = pend_q;
  end

endmodule

// File: tb/tb_clk_div_bank.sv
// Randomized bench for clk_div_bank against a period-position model.
// Directed reset/write/enable scenarios first, then random traffic.
module tb_clk_div_bank;
  localparam int NCH = 5;
  localparam int CW  = 8;
  localparam int RD  = 2;

  logic           clk = 1'b0;
  logic           reset;
  logic           wr_en;
  logic [2:0]     wr_ch;
  logic [CW-1:0]  wr_div;
  logic [NCH-1:0] ch_en;
  logic [NCH-1:0] div_clk;
  logic [NCH-1:0] tick;
  logic [NCH-1:0] busy;

  int n_chk = 0;
  int n_err = 0;

  int m_pos  [NCH];
  int m_div  [NCH];
  int m_sdiv [NCH];
  bit m_pend [NCH];
  bit m_clk  [NCH];
  bit m_tick [NCH];

  clk_div_bank #(
    .NUM_CH(NCH),
    .CNT_W(CW),
    .RST_DIV(RD)
  ) dut (
    .clk(clk),
    .reset(reset),
    .wr_en(wr_en),
    .wr_ch(wr_ch),
    .wr_div(wr_div),
    .ch_en(ch_en),
    .div_clk(div_clk),
    .tick(tick),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %h expected %h",
               tag, $time, got, exp);
    end
  endtask

  function automatic void m_reset();
    for (int c = 0; c < NCH; c++) begin
      m_pos[c]  = 0;
      m_div[c]  = RD;
      m_sdiv[c] = RD;
      m_pend[c] = 0;
      m_clk[c]  = 0;
      m_tick[c] = 0;
    end
  endfunction

  // Position within the current period; a period of length
  // d is high for its first d/2 positions, starts with tick.
  function automatic void m_step();
    for (int c = 0; c < NCH; c++) begin
      bit wr;
      wr = wr_en && (int'(wr_ch) == c) && (wr_div != 0);
      if (!ch_en[c]) begin
        if (m_pend[c]) begin
          m_div[c]  = m_sdiv[c];
          m_pend[c] = 0;
        end
        m_pos[c]  = 0;
        m_clk[c]  = 0;
        m_tick[c] = 0;
      end else begin
        if (m_pos[c] + 1 >= m_div[c]) begin
          if (m_pend[c]) begin
            m_div[c]  = m_sdiv[c];
            m_pend[c] = 0;
          end
          m_pos[c] = 0;
        end else begin
          m_pos[c] = m_pos[c] + 1;
        end
        m_clk[c]  = (m_pos[c] < m_div[c] / 2);
        m_tick[c] = (m_pos[c] == 0);
      end
      if (wr) begin
        m_sdiv[c] = int'(wr_div);
        m_pend[c] = 1;
      end
    end
  endfunction

  task automatic compare_all();
    logic [NCH-1:0] ec, et, eb;
    for (int c = 0; c < NCH; c++) begin
      ec[c] = m_clk[c];
      et[c] = m_tick[c];
      eb[c] = m_pend[c];
    end
    chk("div_clk", 32'(div_clk), 32'(ec));
    chk("tick", 32'(tick), 32'(et));
    chk("busy", 32'(busy), 32'(eb));
  endtask

  task automatic cycle();
    @(posedge clk);
    m_step();
    @(negedge clk);
    compare_all();
  endtask

  task automatic wr_once(input int ch, input int dv);
    wr_en  = 1'b1;
    wr_ch  = 3'(ch);
    wr_div = CW'(dv);
    cycle();
    wr_en  = 1'b0;
  endtask

  // Called just after a negedge; reset pulses between edges.
  task automatic async_reset();
    #2 reset = 1'b1;
    #1;
    m_reset();
    chk("rst_clk", 32'(div_clk), 32'd0);
    chk("rst_tick", 32'(tick), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    #1 reset = 1'b0;
  endtask

  initial begin
    reset  = 1'b1;
    wr_en  = 1'b0;
    wr_ch  = '0;
    wr_div = '0;
    ch_en  = '1;
    m_reset();
    #1;
    chk("init_clk", 32'(div_clk), 32'd0);
    chk("init_tick", 32'(tick), 32'd0);
    chk("init_busy", 32'(busy), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Reset divisor free-running: 0,1,0,1 after first edge.
    repeat (6) cycle();

    // Mid-period divisor write on ch1.
    cycle();
    wr_once(1, 5);
    repeat (14) cycle();

    // Invalid writes: zero divisor, out-of-range channel.
    wr_once(2, 0);
    wr_once(NCH, 3);
    wr_once(7, 4);
    repeat (4) cycle();

    // Hold ch2 disabled for 7 cycles.
    ch_en[2] = 1'b0;
    repeat (7) cycle();
    ch_en[2] = 1'b1;
    repeat (8) cycle();

    // ch3 to divide-by-1, then back-to-back rewrite.
    wr_once(3, 1);
    repeat (5) cycle();
    wr_once(3, 3);
    repeat (9) cycle();

    // Async reset while ch0 has a pending write.
    wr_once(0, 6);
    async_reset();
    repeat (6) cycle();

    // Random traffic.
    for (int n = 0; n < 3000; n++) begin
      wr_en  = ($urandom_range(0, 3) == 0);
      wr_ch  = 3'($urandom_range(0, 7));
      wr_div = CW'($urandom_range(0, 7));
      for (int c = 0; c < NCH; c++)
        if ($urandom_range(0, 15) == 0) ch_en[c] = ~ch_en[c];
      if ($urandom_range(0, 299) == 0) begin
        wr_en = 1'b0;
        async_reset();
      end
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/clk_div_bank.md
CLK_DIV_BANK -- requirements
Module: clk_div_bank

Interface
REQ-001 The block SHALL have parameter NUM_CH, default 4, number of independent divider channels (1..16).
REQ-002 The block SHALL have parameter CNT_W, default 16, width of divisor and per-channel counter.
REQ-003 The block SHALL have parameter RST_DIV, default 2, divisor loaded into every channel at reset (1..2^CNT_W-1).
REQ-004 The block SHALL have port clk, input, 1, sole clock; all state SHALL update on its rising edge.
REQ-005 The block SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-006 The block SHALL have port wr_en, input, 1, divisor write strobe, sampled each clk edge.
REQ-007 The block SHALL have port wr_ch, input, CH_W = max(1, clog2(NUM_CH)), target channel of a write.
REQ-008 The block SHALL have port wr_div, input, CNT_W, new divisor value.
REQ-009 The block SHALL have port ch_en, input, NUM_CH, per-channel run enable.
REQ-010 The block SHALL have port div_clk, output, NUM_CH, registered divided clock per channel.
REQ-011 The block SHALL have port tick, output, NUM_CH, registered one-cycle pulse, high in the cycle div_clk[i] rises.
REQ-012 The block SHALL have port busy, output, NUM_CH, high while a written divisor is pending, not yet applied.

Function
REQ-013 Each channel SHALL hold: counter cnt, active divisor div, shadow divisor sdiv, pending flag, output registers div_clk and tick.
REQ-014 Enabled channel, each edge: cnt_next = (cnt == div-1) ? 0 : cnt+1; cnt <= cnt_next.
REQ-015 Enabled channel, each edge: div_clk <= (cnt_next < div>>1); tick <= (cnt_next == 0).
REQ-016 Period SHALL be exactly div clk cycles; div_clk high for floor(div/2) cycles, low for ceil(div/2) cycles.
REQ-017 div == 1: div_clk SHALL stay 0 and tick SHALL be 1 every enabled cycle.
REQ-018 Write: wr_en=1, wr_ch < NUM_CH, wr_div != 0 -> sdiv[wr_ch] <= wr_div, pending <= 1; other writes SHALL be ignored with no state change.
REQ-019 Apply: at the wrap edge (enabled, cnt == div-1) with pending=1 -> div <= sdiv, pending <= 0; div_clk/tick of that edge SHALL use the new div.
REQ-020 Mid-period writes SHALL NOT truncate or stretch the current period; the new divisor takes effect from the next period start.
REQ-021 Disabled channel with pending=1: apply SHALL occur on the next edge.
REQ-022 Write and apply on the same edge, same channel: apply SHALL use the old sdiv; the new value SHALL be stored in sdiv with pending remaining 1.
REQ-023 Repeated writes while pending: the last value SHALL win; busy SHALL remain 1.
REQ-024 busy[i] SHALL equal pending[i] (registered, no combinational path from wr_en).
REQ-025 ch_en[i]=0: on each edge cnt <= 0, div_clk <= 0, tick <= 0; channel is frozen.
REQ-026 Re-enable (ch_en 0->1) SHALL restart the sequence exactly as after reset.
REQ-027 Channels SHALL be fully independent; a write to one channel SHALL not disturb any other channel.
REQ-028 Outputs SHALL be glitch-free flop outputs; no combinational logic after the output registers.

Reset
REQ-029 reset=1 SHALL immediately, without clk, force for all channels: cnt=0, div=sdiv=RST_DIV, pending=0, div_clk=0, tick=0, busy=0.
REQ-030 Reset asserted mid-period or with a write pending SHALL discard the pending write.
REQ-031 After reset deassertion, the first edge SHALL begin the REQ-014 sequence from cnt=0.

Verification
REQ-032 Reset release, RST_DIV=2, ch_en=all 1 -> div_clk[i] = 0,0,1,0,1... per edge; tick coincides with each rise.
REQ-033 Write wr_ch=1, wr_div=5 mid-period -> busy[1]=1 until the ch1 wrap edge; then ch1 period 5 (high 2, low 3); ch0 unchanged.
REQ-034 Write wr_div=0 or wr_ch=NUM_CH (NUM_CH=3) -> no busy, no divisor change on any channel.
REQ-035 ch_en[2] cleared for 7 cycles, then set -> div_clk[2]=tick[2]=0 while disabled; resumes as in REQ-032.
REQ-036 Write wr_div=1 to ch3 -> after apply, tick[3]=1 every cycle, div_clk[3]=0; write wr_div=3 on the wrap edge -> pending kept, applied at next wrap.
REQ-037 Assert reset asynchronously between clk edges with ch0 pending -> all outputs 0 immediately; busy=0; divisors return to RST_DIV.
